// File: rtl/anf_fl_tex_coord_unit_if.sv
// Request/response bundle for the texture coordinate denormaliser.
// master: shader-side driver of requests and consumer of results.
// slave : the coordinate unit (accepts requests, produces results).
// Ports: in_valid/in_ready/in_u/in_v/in_exp_u/in_exp_v/in_mode_u/in_mode_v/in_tag,
//        out_valid/out_ready/out_idx_u/out_idx_v/out_border/out_idx1_u/out_idx1_v/
//        out_wt_u/out_wt_v/out_tag.
interface anf_fl_tex_coord_unit_if #(
  parameter int COORD_W  = 32,
  parameter int MAX_EXP  = 15,
  parameter int WEIGHT_W = 4,
  parameter int TAG_W    = 8
);
  localparam int IDX_W = MAX_EXP;
  localparam int EXP_W = $clog2(MAX_EXP + 1);

  logic                in_valid;
  logic                in_ready;
  logic [COORD_W-1:0]  in_u;
  logic [COORD_W-1:0]  in_v;
  logic [EXP_W-1:0]    in_exp_u;
  logic [EXP_W-1:0]    in_exp_v;
  logic [1:0]          in_mode_u;
  logic [1:0]          in_mode_v;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_idx_u;
  logic [IDX_W-1:0]    out_idx_v;
  logic                out_border;
  logic [IDX_W-1:0]    out_idx1_u;
  logic [IDX_W-1:0]    out_idx1_v;
  logic [WEIGHT_W-1:0] out_wt_u;
  logic [WEIGHT_W-1:0] out_wt_v;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_u, in_v, in_exp_u, in_exp_v, in_mode_u, in_mode_v, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_idx_u, out_idx_v, out_border, out_idx1_u, out_idx1_v,
    input  out_wt_u, out_wt_v, out_tag
  );

  modport slave (
    input  in_valid, in_u, in_v, in_exp_u, in_exp_v, in_mode_u, in_mode_v, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_idx_u, out_idx_v, out_border, out_idx1_u, out_idx1_v,
    output out_wt_u, out_wt_v, out_tag
  );
endinterface

// File: rtl/anf_fl_tex_coord_unit.sv
// Purpose: denormalise signed fixed-point (U,V) coords to texel indices with per-axis
//          power-of-two size and repeat/mirror/clamp/border wrap; tag passes through.
// Latency: 2 register stages (S1 = scaled integer coord, S2 = wrapped output), 1/cycle.
// Backpressure: out_ready low stalls S2, then S1; in_ready = ~s1_valid | s1_adv.
// Ports: clk, rst_n (async active-low), bus (anf_fl_tex_coord_unit_if.slave).
// Option: define TEX_COORD_BILERP_EN for half-texel offset, neighbour index and weights;
//         otherwise out_idx1_* and out_wt_* are tied to 0.
module anf_fl_tex_coord_unit #(
  parameter int COORD_W  = 32,
  parameter int FRAC_W   = 16,
  parameter int MAX_EXP  = 15,
  parameter int WEIGHT_W = 4,
  parameter int TAG_W    = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  anf_fl_tex_coord_unit_if.slave bus
);
  localparam int IDX_W = MAX_EXP;
  localparam int EXP_W = $clog2(MAX_EXP + 1);
  localparam int INT_W = COORD_W - FRAC_W + MAX_EXP;
  // One spare integer bit so the half-texel subtract and i+1 can never wrap,
  // even for the most negative/positive coord at the largest size.
  localparam int I_W   = INT_W + 1;
  localparam int P_W   = I_W + FRAC_W;

  localparam logic [1:0] MODE_REPEAT = 2'b00;
  localparam logic [1:0] MODE_MIRROR = 2'b01;
  localparam logic [1:0] MODE_CLAMP  = 2'b10;
  localparam logic [1:0] MODE_BORDER = 2'b11;

  typedef struct packed {
    logic [I_W-1:0]      i;     // floor of scaled coord, two's complement
    logic [EXP_W-1:0]    e;     // saturated log2 size
    logic [1:0]          mode;
`ifdef TEX_COORD_BILERP_EN
    logic [WEIGHT_W-1:0] wt;    // top fraction bits toward neighbour
`endif
  } axis_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             oob;      // i outside [0, N)
  } wrap_t;

  typedef struct packed {
    logic [IDX_W-1:0]    idx_u;
    logic [IDX_W-1:0]    idx_v;
    logic                border;
    logic [TAG_W-1:0]    tag;
`ifdef TEX_COORD_BILERP_EN
    logic [IDX_W-1:0]    idx1_u;
    logic [IDX_W-1:0]    idx1_v;
    logic [WEIGHT_W-1:0] wt_u;
    logic [WEIGHT_W-1:0] wt_v;
`endif
  } res_t;

  // S1 per-axis math: sign-extend, scale by 2^exp, optional half-texel shift, floor.
  function automatic axis_t s1_axis(input logic [COORD_W-1:0] coord,
                                    input logic [EXP_W-1:0]   exp_raw,
                                    input logic [1:0]         mode);
    axis_t            r;
    logic [EXP_W-1:0] e;
    logic [P_W-1:0]   p;
    e = (32'(exp_raw) > MAX_EXP) ? EXP_W'(MAX_EXP) : exp_raw;
    p = {{(P_W-COORD_W){coord[COORD_W-1]}}, coord} << e;
`ifdef TEX_COORD_BILERP_EN
    p    = p - (P_W'(1) << (FRAC_W - 1));
    r.wt = WEIGHT_W'(p >> (FRAC_W - WEIGHT_W));
`endif
    // Dropping the fraction bits of a two's complement value is floor().
    r.i    = I_W'(p >> FRAC_W);
    r.e    = e;
    r.mode = mode;
    return r;
  endfunction

  // S2 wrap of an integer texel coordinate into [0, 2^e).
  function automatic wrap_t wrap_idx(input logic [I_W-1:0]   i,
                                     input logic [EXP_W-1:0] e,
                                     input logic [1:0]       mode);
    wrap_t          r;
    logic [I_W-1:0] n;
    logic [I_W-1:0] n2;
    logic [I_W-1:0] m;
    logic [I_W-1:0] res;
    logic           neg;
    n   = I_W'(1) << e;
    n2  = n << 1;
    neg = i[I_W-1];
    // A negative i compares as a huge unsigned value, so it is out of range too.
    r.oob = neg | (i >= n);
    m     = i & (n2 - I_W'(1));
    case (mode)
      MODE_REPEAT: res = i & (n - I_W'(1));
      MODE_MIRROR: res = (m < n) ? m : (n2 - I_W'(1) - m);
      MODE_CLAMP:  res = neg ? '0 : ((i >= n) ? (n - I_W'(1)) : i);
      default:     res = r.oob ? '0 : i;
    endcase
    r.idx = IDX_W'(res);
    return r;
  endfunction

  logic             s1_valid_d, s1_valid_q;
  axis_t            s1_u_d, s1_u_q;
  axis_t            s1_v_d, s1_v_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;
  logic             out_valid_d, out_valid_q;
  res_t             out_d, out_q;

  logic             s1_adv;
  logic             s2_adv;
  wrap_t            w_u, w_v;
`ifdef TEX_COORD_BILERP_EN
  wrap_t            w1_u, w1_v;
`endif

  assign s2_adv       = ~out_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    w_u = wrap_idx(s1_u_q.i, s1_u_q.e, s1_u_q.mode);
    w_v = wrap_idx(s1_v_q.i, s1_v_q.e, s1_v_q.mode);
`ifdef TEX_COORD_BILERP_EN
    w1_u = wrap_idx(s1_u_q.i + I_W'(1), s1_u_q.e, s1_u_q.mode);
    w1_v = wrap_idx(s1_v_q.i + I_W'(1), s1_v_q.e, s1_v_q.mode);
`endif

    s1_valid_d  = s1_valid_q;
    s1_u_d      = s1_u_q;
    s1_v_d      = s1_v_q;
    s1_tag_d    = s1_tag_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    // Input fields are only captured on an accepting edge.
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_u_d   = s1_axis(bus.in_u, bus.in_exp_u, bus.in_mode_u);
        s1_v_d   = s1_axis(bus.in_v, bus.in_exp_v, bus.in_mode_v);
        s1_tag_d = bus.in_tag;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d.idx_u  = w_u.idx;
        out_d.idx_v  = w_v.idx;
        out_d.border = ((s1_u_q.mode == MODE_BORDER) && w_u.oob) ||
                       ((s1_v_q.mode == MODE_BORDER) && w_v.oob);
        out_d.tag    = s1_tag_q;
`ifdef TEX_COORD_BILERP_EN
        out_d.border = out_d.border ||
                       ((s1_u_q.mode == MODE_BORDER) && w1_u.oob) ||
                       ((s1_v_q.mode == MODE_BORDER) && w1_v.oob);
        out_d.idx1_u = w1_u.idx;
        out_d.idx1_v = w1_v.idx;
        out_d.wt_u   = s1_u_q.wt;
        out_d.wt_v   = s1_v_q.wt;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_u_q      <= '0;
      s1_v_q      <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_u_q      <= s1_u_d;
      s1_v_q      <= s1_v_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx_u  = out_q.idx_u;
  assign bus.out_idx_v  = out_q.idx_v;
  assign bus.out_border = out_q.border;
  assign bus.out_tag    = out_q.tag;
`ifdef TEX_COORD_BILERP_EN
  assign bus.out_idx1_u = out_q.idx1_u;
  assign bus.out_idx1_v = out_q.idx1_v;
  assign bus.out_wt_u   = out_q.wt_u;
  assign bus.out_wt_v   = out_q.wt_v;
`else
  assign bus.out_idx1_u = IDX_W'(0);
  assign bus.out_idx1_v = IDX_W'(0);
  assign bus.out_wt_u   = WEIGHT_W'(0);
  assign bus.out_wt_v   = WEIGHT_W'(0);
`endif
endmodule

// File: tb/tb_anf_fl_tex_coord_unit.sv
// Directed bench for anf_fl_tex_coord_unit: vector table through the pipeline,
// latency, backpressure/ordering and asynchronous reset flush.
module tb_anf_fl_tex_coord_unit;
  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] C = 2'b10;
  localparam logic [1:0] B = 2'b11;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  anf_fl_tex_coord_unit_if bus ();

  anf_fl_tex_coord_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] u;
    logic [3:0]  eu;
    logic [1:0]  mu;
    logic [31:0] v;
    logic [3:0]  ev;
    logic [1:0]  mv;
    logic [14:0] xu;
    logic [14:0] xv;
    logic        xb;
    logic [14:0] x1u;
    logic [14:0] x1v;
    logic [3:0]  xwu;
    logic [3:0]  xwv;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] u, input logic [3:0] eu, input logic [1:0] mu,
                              input logic [31:0] v, input logic [3:0] ev, input logic [1:0] mv,
                              input logic [14:0] xu, input logic [14:0] xv, input logic xb,
                              input logic [14:0] x1u, input logic [14:0] x1v,
                              input logic [3:0] xwu, input logic [3:0] xwv);
    vec_t t;
    t.u = u; t.eu = eu; t.mu = mu; t.v = v; t.ev = ev; t.mv = mv;
    t.xu = xu; t.xv = xv; t.xb = xb; t.x1u = x1u; t.x1v = x1v; t.xwu = xwu; t.xwv = xwv;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic drive(input vec_t t, input logic [7:0] tag);
    bus.in_u      = t.u;
    bus.in_exp_u  = t.eu;
    bus.in_mode_u = t.mu;
    bus.in_v      = t.v;
    bus.in_exp_v  = t.ev;
    bus.in_mode_v = t.mv;
    bus.in_tag    = tag;
  endtask

  task automatic check_out(input string name, input vec_t t, input logic [7:0] tag);
    check({name, " idx_u"},  64'(bus.out_idx_u),  64'(t.xu));
    check({name, " idx_v"},  64'(bus.out_idx_v),  64'(t.xv));
    check({name, " border"}, 64'(bus.out_border), 64'(t.xb));
    check({name, " idx1_u"}, 64'(bus.out_idx1_u), 64'(t.x1u));
    check({name, " idx1_v"}, 64'(bus.out_idx1_v), 64'(t.x1v));
    check({name, " wt_u"},   64'(bus.out_wt_u),   64'(t.xwu));
    check({name, " wt_v"},   64'(bus.out_wt_v),   64'(t.xwv));
    check({name, " tag"},    64'(bus.out_tag),    64'(tag));
  endtask

  // Single request through an otherwise idle pipeline with out_ready held high.
  task automatic apply(input vec_t t, input int k);
    int    n;
    string name;
    name = $sformatf("vec%0d", k);
    @(negedge clk);
    drive(t, 8'(8'h10 + k));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout({name, " accept"});
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout({name, " result"});
    else check_out(name, t, 8'(8'h10 + k));
  endtask

  task automatic set_hs(input int k);
    bus.in_u      = 32'(k) << 14;   // k * 0.25
    bus.in_exp_u  = 4'd4;
    bus.in_mode_u = R;
    bus.in_v      = 32'hFFFF_0000 - (32'(k) << 16);
    bus.in_exp_v  = 4'd4;
    bus.in_mode_v = C;
    bus.in_tag    = 8'(8'hA0 + k);
  endtask

  vec_t vecs[$];

  initial begin
    int          send, recv, stall_seen, n;
    logic        acc, prev_vld, prev_rdy;
    logic [7:0]  prev_tag;
    logic [14:0] prev_idx;

    errors = 0;
    checks = 0;

`ifndef TEX_COORD_BILERP_EN
    vecs.push_back(mk(32'h0001_8000, 4, R, 32'hFFFF_C000, 4, R, 15'd8,  15'd12, 1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0001_4000, 2, M, 32'hFFFF_C000, 2, M, 15'd2,  15'd0,  1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0000_C000, 2, M, 32'h0000_C000, 2, R, 15'd3,  15'd3,  1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'hFFFD_0000, 3, C, 32'h0002_0000, 3, C, 15'd0,  15'd7,  1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'hFFFD_0000, 3, B, 32'h0000_8000, 3, C, 15'd0,  15'd4,  1'b1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0000_8000, 3, B, 32'h0000_8000, 3, B, 15'd4,  15'd4,  1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0000_8000, 3, R, 32'h0002_0000, 3, B, 15'd4,  15'd0,  1'b1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0001_8000, 0, R, 32'h0001_8000, 0, B, 15'd0,  15'd0,  1'b1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0000_8000, 0, B, 32'hFFFF_8000, 0, C, 15'd0,  15'd0,  1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h8000_0000, 15, R, 32'h7FFF_FFFF, 15, R, 15'd0, 15'h7FFF, 1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h8000_0000, 15, C, 32'h7FFF_FFFF, 15, C, 15'd0, 15'h7FFF, 1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0001_8000, 3, M, 32'h0002_C000, 1, M, 15'd3,  15'd1,  1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h8000_0000, 15, B, 32'h7FFF_FFFF, 15, B, 15'd0, 15'd0, 1'b1, 0, 0, 0, 0));
`else
    vecs.push_back(mk(32'h0000_8000, 2, R, 32'h0000_FD70, 2, R, 15'd1, 15'd3, 1'b0, 15'd2, 15'd0, 4'h8, 4'h7));
    vecs.push_back(mk(32'h0000_0000, 2, B, 32'h0000_8000, 2, C, 15'd0, 15'd1, 1'b1, 15'd0, 15'd2, 4'h8, 4'h8));
    vecs.push_back(mk(32'h0000_8000, 1, M, 32'h0000_F000, 1, C, 15'd0, 15'd1, 1'b0, 15'd1, 15'd1, 4'h8, 4'h6));
`endif

    // Reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(vecs[0], 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst idx_u",     64'(bus.out_idx_u), 64'd0);
    check("rst idx_v",     64'(bus.out_idx_v), 64'd0);
    check("rst border",    64'(bus.out_border), 64'd0);
    check("rst tag",       64'(bus.out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);

    // Latency: accepted at edge k, in S1 after k, on the output after k+1
    @(negedge clk);
    drive(vecs[0], 8'h5A);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("lat stage1 out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("lat stage2 out_valid", 64'(bus.out_valid), 64'd1);
    check("lat stage2 tag",       64'(bus.out_tag), 64'h5A);
    @(negedge clk);
    #1;
    check("lat no duplicate", 64'(bus.out_valid), 64'd0);

    // Vector table
    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    // Back-to-back stream with out_ready low for cycles 3..6
    send = 0; recv = 0; stall_seen = 0;
    acc = 1'b0; prev_vld = 1'b0; prev_rdy = 1'b1; prev_tag = '0; prev_idx = '0;
    @(negedge clk);
    set_hs(0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (acc) begin
        send++;
        if (send < 8) set_hs(send);
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = !(c >= 3 && c <= 6);
      #1;
      if (prev_vld && !prev_rdy) begin
        check("hs hold valid", 64'(bus.out_valid), 64'd1);
        check("hs hold tag",   64'(bus.out_tag),   64'(prev_tag));
        check("hs hold idx_u", 64'(bus.out_idx_u), 64'(prev_idx));
      end
      if (bus.in_valid && !bus.in_ready) begin
        stall_seen++;
        check("hs buffered when in_ready low", 64'(send - recv), 64'd2);
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("hs tag %0d", recv),   64'(bus.out_tag),   64'(8'hA0 + recv));
        check($sformatf("hs idx_u %0d", recv), 64'(bus.out_idx_u), 64'((4 * recv) & 15));
        check($sformatf("hs idx_v %0d", recv), 64'(bus.out_idx_v), 64'd0);
        recv++;
      end
      acc      = bus.in_valid && bus.in_ready;
      prev_vld = bus.out_valid;
      prev_rdy = bus.out_ready;
      prev_tag = bus.out_tag;
      prev_idx = bus.out_idx_u;
    end
    if (recv < 8) timeout("hs all results");
    check("hs in_ready dropped", 64'(stall_seen != 0), 64'd1);
    check("hs all accepted", 64'(send), 64'd8);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("hs no extra result", 64'(bus.out_valid), 64'd0);
    end

    // Asynchronous reset with two requests in flight
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(vecs[1], 8'hC1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[2], 8'hC2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("flush pre out_valid", 64'(bus.out_valid), 64'd1);
    check("flush pre in_ready",  64'(bus.in_ready),  64'd0);
    rst_n = 1'b0;
    #1;
    check("flush out_valid", 64'(bus.out_valid), 64'd0);
    check("flush tag",       64'(bus.out_tag),   64'd0);
    check("flush in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("flush no stale result", 64'(bus.out_valid), 64'd0);
    end

    // Recovery after reset
    apply(vecs[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global: simulation time limit reached");
    $fatal(1);
  end
endmodule
